// File: rtl/tx_bit_sequencer.sv
// Frame sequencer for the ISO 14443-2A PICC->PCD path: SOC bit, LSB-first data, odd parity.
// Build option: define TX_PARITY_EN to insert parity bits (undefined: bit-oriented bring-up).
module tx_bit_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic [2:0] in_bits,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       enc_en,
   output logic       enc_data,
   output logic       enc_last,
   input  logic       enc_req,
   input  logic       enc_last_tick,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StSoc, StData, StParity, StFinish} state_e;
`else
   typedef enum logic [2:0] {StIdle, StSoc, StData, StFinish} state_e;
`endif

   state_e     state_q, state_d;
   logic [7:0] cur_data_q, cur_data_d;
   logic [2:0] cur_bits_q, cur_bits_d;
   logic       cur_last_q, cur_last_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] pf_data_q, pf_data_d;
   logic [2:0] pf_bits_q, pf_bits_d;
   logic       pf_last_q, pf_last_d;
   logic       pf_valid_q, pf_valid_d;
   logic       enc_en_q, enc_en_d;
   logic       done_q, done_d;
   logic       underrun_q, underrun_d;

   logic       partial;
   logic [2:0] last_idx;
   logic       at_last;
   logic       pf_room;
   logic       in_ready_c;
   logic       enc_data_c;
   logic       enc_last_c;

   // A partial byte only ever occurs as the last byte of a frame and carries no parity.
   assign partial  = cur_last_q && (cur_bits_q != 3'd0);
   assign last_idx = partial ? (cur_bits_q - 3'd1) : 3'd7;
   assign at_last  = (idx_q == last_idx);

   always_comb begin
      state_d    = state_q;
      cur_data_d = cur_data_q;
      cur_bits_d = cur_bits_q;
      cur_last_d = cur_last_q;
      idx_d      = idx_q;
      pf_data_d  = pf_data_q;
      pf_bits_d  = pf_bits_q;
      pf_last_d  = pf_last_q;
      pf_valid_d = pf_valid_q;
      enc_en_d   = enc_en_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      pf_room    = 1'b0;
      in_ready_c = 1'b0;
      enc_data_c = 1'b0;
      enc_last_c = 1'b0;

      case (state_q)
         StIdle: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               cur_data_d = in_data;
               cur_bits_d = in_bits;
               cur_last_d = in_last;
               enc_en_d   = 1'b1;
               state_d    = StSoc;
            end
         end
         StSoc: begin
            enc_data_c = 1'b1;
            if (enc_req) begin
               idx_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            enc_data_c = cur_data_q[idx_q];
`ifdef TX_PARITY_EN
            enc_last_c = at_last && partial;
            if (enc_req) begin
               if (!at_last) begin
                  idx_d = idx_q + 3'd1;
               end else begin
                  state_d = partial ? StFinish : StParity;
               end
            end
`else
            // No byte may be taken on the request that already announced the final bit.
            pf_room    = !cur_last_q && !pf_valid_q && (idx_q != 3'd0) && !(at_last && enc_req);
            enc_last_c = at_last && (cur_last_q || !pf_valid_q);
            if (enc_req) begin
               if (!at_last) begin
                  idx_d = idx_q + 3'd1;
               end else if (cur_last_q) begin
                  state_d = StFinish;
               end else if (pf_valid_q) begin
                  cur_data_d = pf_data_q;
                  cur_bits_d = pf_bits_q;
                  cur_last_d = pf_last_q;
                  pf_valid_d = 1'b0;
                  idx_d      = 3'd0;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = StFinish;
               end
            end
`endif
         end
`ifdef TX_PARITY_EN
         StParity: begin
            enc_data_c = ~^cur_data_q;
            enc_last_c = cur_last_q || !pf_valid_q;
            pf_room    = !cur_last_q && !pf_valid_q && !enc_req;
            if (enc_req) begin
               if (cur_last_q) begin
                  state_d = StFinish;
               end else if (pf_valid_q) begin
                  cur_data_d = pf_data_q;
                  cur_bits_d = pf_bits_q;
                  cur_last_d = pf_last_q;
                  pf_valid_d = 1'b0;
                  idx_d      = 3'd0;
                  state_d    = StData;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = StFinish;
               end
            end
         end
`endif
         StFinish: begin
            if (enc_last_tick) begin
               enc_en_d = 1'b0;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (pf_room) begin
         in_ready_c = 1'b1;
         if (in_valid) begin
            pf_data_d  = in_data;
            pf_bits_d  = in_bits;
            pf_last_d  = in_last;
            pf_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cur_data_q <= 8'd0;
         cur_bits_q <= 3'd0;
         cur_last_q <= 1'b0;
         idx_q      <= 3'd0;
         pf_data_q  <= 8'd0;
         pf_bits_q  <= 3'd0;
         pf_last_q  <= 1'b0;
         pf_valid_q <= 1'b0;
         enc_en_q   <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_data_q <= cur_data_d;
         cur_bits_q <= cur_bits_d;
         cur_last_q <= cur_last_d;
         idx_q      <= idx_d;
         pf_data_q  <= pf_data_d;
         pf_bits_q  <= pf_bits_d;
         pf_last_q  <= pf_last_d;
         pf_valid_q <= pf_valid_d;
         enc_en_q   <= enc_en_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign in_ready = in_ready_c && rst_n;
   assign enc_en   = enc_en_q;
   assign busy     = enc_en_q;
   assign enc_data = enc_data_c;
   assign enc_last = enc_last_c;
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule

// File: doc/tx_bit_sequencer.md
# tx_bit_sequencer

Frame-level sequencer for the ISO/IEC 14443-2A PICC→PCD transmit path: accepts bytes from the upstream frame logic and feeds `bit_encoder` one bit per bit-encoder request, inserting the start-of-communication bit and the odd parity bits. It owns the encoder's `en` and ends the frame after the encoder's `last_tick`. It sits between the byte-oriented TX framing and `bit_encoder` in the iso14443_2a tier.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  13.56 MHz carrier clock.
- `rst_n`  in  1  reset; synchronous, active low.
- `in_data`  in  8  byte to send, LSB transmitted first.
- `in_bits`  in  3  valid bits in a last byte (1–7); 0 = full byte. Ignored unless `in_last`.
- `in_last`  in  1  this byte ends the frame.
- `in_valid`  in  1  upstream byte available.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `enc_en`  out  1  drives `bit_encoder.en`.
- `enc_data`  out  1  bit presented to encoder.
- `enc_last`  out  1  presented bit is final bit of frame.
- `enc_req`  in  1  encoder bit request; single-cycle pulse every 128 ticks while enabled.
- `enc_last_tick`  in  1  encoder's final tick of current bit period.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `underrun`  out  1  one-cycle pulse: next byte missing when required.

## Operation
- States: IDLE, SOC, DATA, PARITY, FINISH.
- IDLE: `in_ready`=1. On accept: latch byte/bits/last into a current register, `enc_en`←1, go to SOC.
- SOC: `enc_data`=1, `enc_last`=0. On `enc_req` → DATA, bit index 0.
- DATA: `enc_data`=current[idx]. On `enc_req`: if idx is last valid bit (7, or `in_bits`−1 for partial last byte) → PARITY when byte is full, else → FINISH; otherwise idx+1.
- PARITY: `enc_data` = ~^current (odd parity over 8 data bits). If current byte not last, `in_ready`=1 and a byte accepted here goes to a one-entry prefetch register. On `enc_req`: if last byte → FINISH; else if prefetch full → load it, DATA idx 0; else pulse `underrun` and → FINISH (parity bit already sent becomes the frame's final bit).
- `enc_last`=1 combinationally while presenting the final bit: DATA at last valid bit of a partial last byte; PARITY of a last byte; PARITY with no prefetch.
- FINISH: wait for `enc_last_tick`; at that edge `enc_en`←0, `busy`←0, `done` pulses, → IDLE.
- Partial last byte: no parity bit.

## Timing
- Reset values: `in_ready`=0 during reset, 1 the cycle after release (IDLE); `enc_en`, `enc_data`, `enc_last`, `busy`, `done`, `underrun` all 0.
- `enc_data`/`enc_last` valid in every cycle `enc_req`=1; change only on the edge at which `enc_req` is sampled, or on a load.
- Accept→`enc_en` high: 1 cycle. `busy` rises with `enc_en`.
- `in_ready` is 0 in SOC, DATA, FINISH, and in PARITY once prefetch full.
- `enc_req` and `enc_last_tick` in same cycle in FINISH: `enc_req` ignored.
- `enc_req` in IDLE: ignored.
- `rst_n` low mid-frame: next edge returns to IDLE with all outputs at reset values; prefetch discarded; no `done`.
- Frame of N full bytes = 1 + 9N bit periods = 128·(1+9N) clocks of `enc_en` high (±1 cycle for enable/last_tick alignment).

## Configuration
- `TX_PARITY_EN` defined: behaviour as above.
- Undefined: PARITY state removed; after bit 7 of a non-last byte the prefetch byte is loaded directly (underrun check moves to bit 7's `enc_req`; `in_ready` asserted during DATA once idx ≥ 1 and prefetch empty); full last byte ends on bit 7 with `enc_last`=1. Bit-oriented bring-up only.

## Test plan
- Single byte 0x00, `in_last`, `in_bits`=0 → encoder bits 1,0×8,1(parity); `enc_last` only on parity; `done` one cycle after final `last_tick`; `enc_en` high 1280±1 clocks.
- 0xA5, `in_last`, `in_bits`=4 → bits 1,1,0,1,0; no parity; `enc_last` on 4th data bit.
- Two bytes 0x01 then 0xFF (last), second presented during first parity → bits 1,10000000,0,11111111,1; no `underrun`.
- 0x3C not last, no second byte → bits 1,00111100,1; `underrun` pulses once at parity `enc_req`; frame ends, `done` pulses.
- `rst_n` low for 1 cycle mid-DATA of 0x55 → next cycle `enc_en`=0, `busy`=0, `in_ready`=1, no `done`; a following frame 0x00 sends correctly.
- `TX_PARITY_EN` undefined, 0x81 then 0x02 (last) → bits 1,10000001,01000000; 17 bit periods.
